// File: rtl/onchip_ram_arbiter_pkg.sv
// Shared constants and types for the two-master on-chip RAM arbiter.
package onchip_ram_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;

    // RAM q arrives one cycle after the address, plus one output register stage
    localparam int RD_LATENCY = 2;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_t;

endpackage

// File: rtl/onchip_ram_arbiter_if.sv
// Avalon-MM style master bundle: request side from the master, response side back to it.
interface onchip_ram_arbiter_if #(
    parameter int ADDR_W = onchip_ram_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = onchip_ram_arb_pkg::DEF_DATA_W,
    parameter int BE_W   = onchip_ram_arb_pkg::DEF_BE_W
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_ram_arbiter_rr_arb2.sv
// Two-request arbiter: round-robin on ties, or m0-wins when FIXED_PRIORITY is set.
module rr_arb2
    import onchip_ram_arb_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    owner_t last_grant;

    // Grant decision from current requests and the previous winner
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (FIXED_PRIORITY != 0 || last_grant == M1) gnt = 2'b01;
                else                                         gnt = 2'b10;
            end
            default: gnt = 2'b00;
        endcase
    end

    // Remember the winner only on cycles that actually issue a grant; m0 wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            last_grant <= M1;
        else if (gnt != 2'b00)   last_grant <= gnt[1] ? M1 : M0;
    end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Shares one single-port RAM between two masters: grant, request mux, read tag pipeline, response demux.
module onchip_ram_arbiter
    import onchip_ram_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int BE_W           = DEF_BE_W,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    onchip_ram_arbiter_if.slave  m0,
    onchip_ram_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0]    ram_address,
    output logic [BE_W-1:0]      ram_byteenable,
    output logic [DATA_W-1:0]    ram_writedata,
    output logic                 ram_chipselect,
    output logic                 ram_write,
    output logic                 ram_clken,
    input  logic [DATA_W-1:0]    ram_readdata
);

    logic [1:0]        rst_sync;
    logic              ready;
    logic              m0_req;
    logic              m1_req;
    logic [1:0]        gnt;
    logic              any_gnt;
    logic [ADDR_W-1:0] mux_address;
    logic [BE_W-1:0]   mux_byteenable;
    logic [DATA_W-1:0] mux_writedata;
    logic              mux_read;
    logic              mux_write;
    logic [ADDR_W-1:0] hold_address;
    logic [BE_W-1:0]   hold_byteenable;
    logic [DATA_W-1:0] hold_writedata;
    logic              s1_valid;
    owner_t            s1_owner;

    // Synchronise reset release; RAM clocking and grants both wait for it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign ready     = rst_sync[1];
    assign ram_clken = ready;

    assign m0_req = m0.read | m0.write;
    assign m1_req = m1.read | m1.write;

    rr_arb2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({ready & m1_req, ready & m0_req}),
        .gnt     (gnt)
    );

    assign any_gnt = |gnt;

    // Select the granted master's request fields
    always_comb begin
        mux_address    = m0.address;
        mux_byteenable = m0.byteenable;
        mux_writedata  = m0.writedata;
        mux_read       = m0.read;
        mux_write      = m0.write;
        if (gnt[1]) begin
            mux_address    = m1.address;
            mux_byteenable = m1.byteenable;
            mux_writedata  = m1.writedata;
            mux_read       = m1.read;
            mux_write      = m1.write;
        end
    end

    // Keep the last issued address/data so the RAM pins stay quiet between grants
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_address    <= '0;
            hold_byteenable <= '0;
            hold_writedata  <= '0;
        end else if (any_gnt) begin
            hold_address    <= mux_address;
            hold_byteenable <= mux_byteenable;
            hold_writedata  <= mux_writedata;
        end
    end

    assign ram_address    = any_gnt ? mux_address    : hold_address;
    assign ram_byteenable = any_gnt ? mux_byteenable : hold_byteenable;
    assign ram_writedata  = any_gnt ? mux_writedata  : hold_writedata;
    assign ram_chipselect = any_gnt;
    assign ram_write      = any_gnt & mux_write;

    assign m0.waitrequest = ~ready | (m0_req & ~gnt[0]);
    assign m1.waitrequest = ~ready | (m1_req & ~gnt[1]);

    // Stage 1: tag the granted read (write wins if both are raised) with its owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_owner <= M0;
        end else begin
            s1_valid <= any_gnt & mux_read & ~mux_write;
            s1_owner <= gnt[1] ? M1 : M0;
        end
    end

    // Stage 2: register RAM q into the owner's readdata and pulse its valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0.readdata      <= '0;
            m1.readdata      <= '0;
            m0.readdatavalid <= 1'b0;
            m1.readdatavalid <= 1'b0;
        end else begin
            m0.readdatavalid <= s1_valid && (s1_owner == M0);
            m1.readdatavalid <= s1_valid && (s1_owner == M1);
            if (s1_valid && (s1_owner == M0)) m0.readdata <= ram_readdata;
            if (s1_valid && (s1_owner == M1)) m1.readdata <= ram_readdata;
        end
    end

endmodule
